hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the five-stage RISC-V pipeline. It keeps a shadow pipeline of destination-register state for the EX, MEM and WB stages. From that state it drives the following:
- per-port forwarding selects
- load-use stalls with bubble insertion
- redirect flushes for a configurable branch-resolve stage
- a global freeze while data memory is busy

It sits beside the PC, IF_ID, ID_EX and EX_MEM registers and replaces a purely combinational forwarding unit. It adds saturating stall and flush performance counters.

## Interface
Parameters:
- `RIDX_W`, default 5: register index width.
- `NPORTS`, default 2: source-operand read ports, range 1..3.
- `RESOLVE_STAGE`, default 2: stage where redirects resolve. 1 = ID, 2 = EX, 3 = MEM.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk` in 1: the single clock. Everything is on the rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state and outputs immediately.
- `id_valid` in 1: a real instruction is in ID.
- `id_rs` in NPORTS*RIDX_W: source indices. Port p is bits [p*RIDX_W +: RIDX_W].
- `id_rs_used` in NPORTS: port p actually reads its register.
- `id_rd` in RIDX_W: ID destination index.
- `id_regwrite` in 1: ID instruction writes rd.
- `id_memread` in 1: ID instruction is a load.
- `redirect` in 1: taken branch or jump resolved this cycle in RESOLVE_STAGE.
- `mem_busy` in 1: data memory is not ready. The whole pipeline freezes.
- `freeze` out 1: hold every pipeline register and the PC.
- `stall_front` out 1: hold the PC and IF_ID. ID_EX loads a bubble.
- `flush` out 3: bit0 clears IF_ID, bit1 clears ID_EX, bit2 clears EX_MEM.
- `fwd_sel` out NPORTS*2: per-port EX operand select. 00 = register file, 01 = EX_MEM alu result, 10 = MEM_WB write data, 11 = reserved.
- `perf_stall` out CNT_W: count of load-use bubble cycles.
- `perf_flush` out CNT_W: count of redirects accepted.

## Operation
Shadow state:
- EX, MEM and WB each hold the tuple {valid, rd, regwrite, memread}.
- When not frozen, the state advances every cycle: ID→EX, EX→MEM, MEM→WB.
- A bubble or flush loads EX with valid=0.
- A flushed stage (flush bit2 → MEM entry) is loaded with valid=0.

Producer match, for port p:
- The port must have `id_rs_used[p]=1` and `id_rs[p]≠0`.
- The candidate stage must have valid=1, regwrite=1 and rd equal to `id_rs[p]`.

Load-use detection:
- Condition: `id_valid`, and any port matches EX with EX.memread=1.
- Response: `stall_front=1`, the EX shadow takes a bubble, and the ID instruction is re-evaluated next cycle.
- Exactly one bubble per load, because the load is in MEM on the retry.

Forwarding selects:
- Computed from ID against the current shadow, then registered into EX alongside the ID tuple.
- A match on the current EX entry gives 01 (it will be in EX_MEM next cycle).
- Otherwise a match on the current MEM entry gives 10.
- Otherwise 00. This covers a match on the WB entry, because the register file is write-through.
- The youngest producer wins.
- A bubble or flush into EX forces `fwd_sel=0`.

Redirect handling:
- `flush` bits [RESOLVE_STAGE-1:0] = 1 in the `redirect` cycle, combinationally. Other bits stay 0.
- Squashed shadow entries lose valid, so they never forward and never stall.

Priority when events coincide:
- `mem_busy` is highest. `freeze=1`, flush=0, stall_front=0, the shadow holds and `fwd_sel` holds. The `redirect` input must be held by the datapath until the freeze releases.
- `redirect` is next. It cancels any load-use stall in the same cycle (the ID instruction is killed) and suppresses the stall count.
- Load-use is lowest.

Performance counters:
- `perf_stall` increments on each cycle where `stall_front=1`.
- `perf_flush` increments once per unfrozen `redirect` cycle.
- Both saturate at all-ones and never wrap.

## Timing
- `freeze`, `stall_front` and `flush` are combinational from the current inputs plus registered shadow state. They are valid in the same cycle.
- `fwd_sel` is registered. It is valid for the whole cycle in which the matching instruction occupies EX, with a latency of 1 from ID.
- The counters update on the clock edge and are visible the cycle after the event.
- Reset values: all shadow valid=0, `fwd_sel=0`, `freeze=0`, `stall_front=0`, `flush=0`, counters=0.
- Reset asserted mid-stall or mid-freeze takes effect immediately. The first cycle after release behaves as an empty pipeline.

## Structure
- Shared package `hazard_pkg`:
  - forwarding encodings FWD_RF, FWD_EXMEM, FWD_MEMWB
  - the flush bit positions
  - the shadow-entry struct {valid, rd, regwrite, memread}
- One natural sub-module: `hazard_src_match`. It is combinational per port, instantiated NPORTS times, and returns the EX hit, MEM hit and load-use hit for that port.
- The shadow pipeline, priority logic and counters stay in the top level.

## Test plan
1. Dependent ALU op: add x5 in ID, then add x7,x5,x1 in the next cycle → no stall; `fwd_sel[port0]=01` during the consumer's EX cycle.
2. Load-use: lw x6 followed by add x7,x6,x6 → one cycle of `stall_front=1` and bubble; then `fwd_sel` = 10 on both ports; `perf_stall` goes 0 → 1.
3. Redirect with RESOLVE_STAGE=2 and a load-use pending in the same cycle → `flush=3'b011`, `stall_front=0`; the squashed producer of x9 causes no forward to a later reader of x9; `perf_flush=1`.
4. `mem_busy` high for 3 cycles during a load-use, with `redirect` held high through that window and released in the cycle `mem_busy` falls → `freeze=1` for 3 cycles; shadow and `fwd_sel` unchanged; `perf_stall` unchanged; the stall and the one flush occur after release.
5. Register x0 and no-writeback cases:
   - Producer rd=x0 → `fwd_sel=00` and no stall.
   - A store (regwrite=0) to a register a later instruction reads → `fwd_sel=00`.
6. Reset low mid-stall → all outputs 0 immediately. With CNT_W=2, force 5 stalls → `perf_stall` saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forwarding select encodings (EX operand mux)
//   - flush bit positions (IF_ID, ID_EX, EX_MEM)
//   - shadow-pipeline entry struct {valid, rd, regwrite, memread}
//   - flush_mask(): which pipeline registers a redirect clears
package hazard_pkg;

    // Widest register index the shadow entry can carry; narrower indices are
    // zero-extended into it.
    localparam int RIDX_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,  // register file (also covers a WB producer: write-through RF)
        FWD_EXMEM = 2'b01,  // EX_MEM alu result
        FWD_MEMWB = 2'b10,  // MEM_WB write data
        FWD_RSVD  = 2'b11
    } fwd_sel_e;

    localparam int FLUSH_IFID  = 0;
    localparam int FLUSH_IDEX  = 1;
    localparam int FLUSH_EXMEM = 2;

    typedef struct packed {
        logic                valid;
        logic [RIDX_MAX-1:0] rd;
        logic                regwrite;
        logic                memread;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

    // A redirect resolved in stage N (1=ID, 2=EX, 3=MEM) kills everything
    // younger than the resolving instruction: flush bits [N-1:0].
    function automatic logic [2:0] flush_mask(input int resolve_stage);
        logic [2:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) m[i] = (i < resolve_stage);
        return m;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: producer match for one source-operand port.
//   rs, rs_used      : source index of the ID instruction and whether it is read
//   ex_ent, mem_ent  : shadow entries currently in EX and MEM
//   ex_hit, mem_hit  : a live producer of rs sits in that stage
//   load_use_hit     : the EX producer is a load (its data is not ready yet)
// x0 never matches: it is hardwired zero, so a write to it produces nothing.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int RIDX_W = 5
) (
    input  logic [RIDX_W-1:0] rs,
    input  logic              rs_used,
    input  shadow_t           ex_ent,
    input  shadow_t           mem_ent,
    output logic              ex_hit,
    output logic              mem_hit,
    output logic              load_use_hit
);

    logic [RIDX_MAX-1:0] rs_ext;
    logic                rs_live;

    always_comb begin
        rs_ext             = '0;
        rs_ext[RIDX_W-1:0] = rs;
    end

    assign rs_live      = rs_used && (rs != '0);
    assign ex_hit       = rs_live && ex_ent.valid  && ex_ent.regwrite  && (ex_ent.rd  == rs_ext);
    assign mem_hit      = rs_live && mem_ent.valid && mem_ent.regwrite && (mem_ent.rd == rs_ext);
    assign load_use_hit = ex_hit && ex_ent.memread;

    // A load already in MEM has its data by the time the consumer reaches EX.
    logic unused_mem_memread;
    assign unused_mem_memread = mem_ent.memread;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the five-stage pipeline.
// Keeps a shadow copy of the destination-register state of EX, MEM and WB and
// from it derives forwarding selects, load-use stalls, redirect flushes and a
// freeze while data memory is busy. Also counts stall and flush events.
//   clk, reset (async, active-low)
//   id_*          : the instruction currently in ID
//   redirect      : taken branch/jump resolved in RESOLVE_STAGE this cycle
//   mem_busy      : data memory not ready, whole pipeline holds
//   freeze        : hold every pipeline register and the PC
//   stall_front   : hold PC and IF_ID, ID_EX loads a bubble
//   flush[2:0]    : clear IF_ID / ID_EX / EX_MEM
//   fwd_sel       : per-port EX operand select, 2 bits per port (registered)
//   perf_stall    : saturating count of load-use bubble cycles
//   perf_flush    : saturating count of accepted redirects
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RIDX_W        = 5,
    parameter int NPORTS        = 2,
    parameter int RESOLVE_STAGE = 2,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [NPORTS*RIDX_W-1:0] id_rs,
    input  logic [NPORTS-1:0]        id_rs_used,
    input  logic [RIDX_W-1:0]        id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     redirect,
    input  logic                     mem_busy,
    output logic                     freeze,
    output logic                     stall_front,
    output logic [2:0]               flush,
    output logic [NPORTS*2-1:0]      fwd_sel,
    output logic [CNT_W-1:0]         perf_stall,
    output logic [CNT_W-1:0]         perf_flush
);

    localparam logic [2:0] FLUSH_MASK = flush_mask(RESOLVE_STAGE);

    shadow_t             ex_q, mem_q, wb_q;
    shadow_t             id_ent;
    logic [NPORTS-1:0]   ex_hit, mem_hit, lu_hit;
    logic [NPORTS*2-1:0] fwd_d;
    logic                load_use;
    logic                redirect_go;
    logic                bubble_ex;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        hazard_src_match #(.RIDX_W(RIDX_W)) u_match (
            .rs           (id_rs[p*RIDX_W +: RIDX_W]),
            .rs_used      (id_rs_used[p]),
            .ex_ent       (ex_q),
            .mem_ent      (mem_q),
            .ex_hit       (ex_hit[p]),
            .mem_hit      (mem_hit[p]),
            .load_use_hit (lu_hit[p])
        );
    end

    // NOTE: every variable in a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        fwd_d = '0;
        if (id_valid) begin
            for (int p = 0; p < NPORTS; p++) begin
                // EX is the youngest producer, so it wins over MEM.
                if (ex_hit[p])       fwd_d[2*p +: 2] = FWD_EXMEM;
                else if (mem_hit[p]) fwd_d[2*p +: 2] = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        id_ent                 = SHADOW_EMPTY;
        id_ent.valid           = id_valid;
        id_ent.rd[RIDX_W-1:0]  = id_rd;
        id_ent.regwrite        = id_regwrite;
        id_ent.memread         = id_memread;
    end

    assign load_use = id_valid && (|lu_hit);

    // Priority: mem_busy > redirect > load-use. Outputs are forced low while
    // reset is held so the datapath sees an idle controller immediately.
    assign freeze      = reset && mem_busy;
    assign redirect_go = reset && redirect && !mem_busy;
    assign flush       = redirect_go ? FLUSH_MASK : 3'b000;
    assign stall_front = reset && !mem_busy && !redirect && load_use;
    assign bubble_ex   = stall_front || flush[FLUSH_IDEX];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain stages in one edge.
    // NOTE: only the valid bits matter after reset, but the whole shadow is
    // cleared so nothing downstream ever sees X in rd/regwrite/memread.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= SHADOW_EMPTY;
            mem_q   <= SHADOW_EMPTY;
            wb_q    <= SHADOW_EMPTY;
            fwd_sel <= '0;
        end else if (!mem_busy) begin
            wb_q    <= mem_q;
            mem_q   <= flush[FLUSH_EXMEM] ? SHADOW_EMPTY : ex_q;
            ex_q    <= bubble_ex ? SHADOW_EMPTY : id_ent;
            fwd_sel <= bubble_ex ? '0 : fwd_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (stall_front && (perf_stall != {CNT_W{1'b1}})) perf_stall <= perf_stall + 1'b1;
            if (redirect_go && (perf_flush != {CNT_W{1'b1}})) perf_flush <= perf_flush + 1'b1;
        end
    end

    // WB is tracked for completeness of the shadow pipeline; a WB producer is
    // served by the write-through register file, so nothing reads it.
    logic unused_wb;
    assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (RESOLVE_STAGE=2, CNT_W=2).
// The stimulus process drives one cycle of inputs, asks a behavioural model for
// the outputs that cycle should show, and queues them; the monitor pops one
// expectation per cycle on the falling edge and compares.
module tb_hazard_ctrl;

    localparam int RW   = 5;
    localparam int NP   = 2;
    localparam int RS   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [NP*RW-1:0]  id_rs;
    logic [NP-1:0]     id_rs_used;
    logic [RW-1:0]     id_rd;
    logic              id_regwrite, id_memread, redirect, mem_busy;
    logic              freeze, stall_front;
    logic [2:0]        flush;
    logic [NP*2-1:0]   fwd_sel;
    logic [CW-1:0]     perf_stall, perf_flush;

    hazard_ctrl #(.RIDX_W(RW), .NPORTS(NP), .RESOLVE_STAGE(RS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .redirect(redirect), .mem_busy(mem_busy),
        .freeze(freeze), .stall_front(stall_front), .flush(flush),
        .fwd_sel(fwd_sel), .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit v; int rd; bit rw; bit mr; } instr_t;
    typedef struct { bit fr; bit st; int fl; int fwd; int ps; int pf; } exp_t;

    instr_t pipe[3];      // [0]=EX, [1]=MEM, [2]=WB
    int     m_fwd[NP];    // selects seen by the instruction now in EX
    int     m_stall, m_flush;
    exp_t   sb[$];

    function automatic instr_t nop();
        instr_t n;
        n.v = 0; n.rd = 0; n.rw = 0; n.mr = 0;
        return n;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = nop();
        for (int p = 0; p < NP; p++) m_fwd[p] = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // One cycle: drive inputs, queue expected outputs, advance the model,
    // then wait until just after the next rising edge.
    task automatic step(input bit rst_v, input bit idv, input int rs0, input int rs1,
                        input bit [1:0] used, input int rd, input bit rw, input bit mr,
                        input bit redir, input bit busy);
        exp_t   e;
        int     src[NP];
        int     sel[NP];
        bit     lu, red_eff, stall, bub;
        instr_t ni;

        reset       = rst_v;
        id_valid    = idv;
        id_rs       = {RW'(rs1), RW'(rs0)};
        id_rs_used  = used;
        id_rd       = RW'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        redirect    = redir;
        mem_busy    = busy;

        if (!rst_v) begin
            e.fr = 0; e.st = 0; e.fl = 0; e.fwd = 0; e.ps = 0; e.pf = 0;
            sb.push_back(e);
            model_clear();
        end else begin
            src[0] = rs0;
            src[1] = rs1;
            lu = 0;
            for (int p = 0; p < NP; p++) begin
                bit found;
                sel[p] = 0;
                found  = 0;
                if (idv && used[p] && src[p] != 0) begin
                    // youngest matching writer decides where the value comes from
                    for (int k = 0; k < 3; k++) begin
                        if (!found && pipe[k].v && pipe[k].rw && pipe[k].rd == src[p]) begin
                            found = 1;
                            if (k == 0) begin
                                sel[p] = 1;
                                if (pipe[k].mr) lu = 1;
                            end else if (k == 1) begin
                                sel[p] = 2;
                            end
                        end
                    end
                end
            end
            red_eff = redir && !busy;
            stall   = !busy && !redir && lu;
            e.fr  = busy;
            e.st  = stall;
            e.fl  = red_eff ? ((1 << RS) - 1) : 0;
            e.fwd = 0;
            for (int p = 0; p < NP; p++) e.fwd += m_fwd[p] << (2 * p);
            e.ps  = m_stall;
            e.pf  = m_flush;
            sb.push_back(e);

            if (!busy) begin
                bub = stall || ((e.fl >> 1) & 1);
                pipe[2] = pipe[1];
                pipe[1] = ((e.fl >> 2) & 1) ? nop() : pipe[0];
                ni.v = idv; ni.rd = rd; ni.rw = rw; ni.mr = mr;
                pipe[0] = bub ? nop() : ni;
                for (int p = 0; p < NP; p++) m_fwd[p] = bub ? 0 : sel[p];
                if (stall && m_stall < CMAX) m_stall++;
                if (red_eff && m_flush < CMAX) m_flush++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("freeze",      int'(freeze),      int'(e.fr));
                check("stall_front", int'(stall_front), int'(e.st));
                check("flush",       int'(flush),       e.fl);
                check("fwd_sel",     int'(fwd_sel),     e.fwd);
                check("perf_stall",  int'(perf_stall),  e.ps);
                check("perf_flush",  int'(perf_flush),  e.pf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit pb, pr;
        model_clear();
        reset = 0; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_regwrite = 0; id_memread = 0; redirect = 0; mem_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset state, even with busy/redirect asserted
        step(0, 1, 1, 1, 2'b11, 1, 1, 1, 1, 1);
        idle(1);

        // 1: dependent ALU op -> EX_MEM forward on port 0
        step(1, 1, 1, 2, 2'b11, 5, 1, 0, 0, 0);
        step(1, 1, 5, 1, 2'b11, 7, 1, 0, 0, 0);
        idle(3);
        check("t1_no_stall_count", int'(perf_stall), 0);

        // 2: load-use -> one bubble, then MEM_WB forward on both ports
        step(1, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        step(1, 1, 6, 6, 2'b11, 7, 1, 0, 0, 0);
        step(1, 1, 6, 6, 2'b11, 7, 1, 0, 0, 0);
        idle(1);
        check("t2_perf_stall", int'(perf_stall), 1);
        idle(2);

        // 3: redirect with load-use pending; the killed x9 producer never forwards
        step(1, 1, 0, 0, 2'b00, 8, 1, 1, 0, 0);
        step(1, 1, 8, 0, 2'b01, 9, 1, 0, 1, 0);
        step(1, 1, 9, 9, 2'b11, 10, 1, 0, 0, 0);
        idle(1);
        check("t3_perf_flush", int'(perf_flush), 1);
        idle(2);

        // 4: freeze for 3 cycles during load-use with redirect held
        step(1, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        repeat (3) step(1, 1, 6, 0, 2'b01, 7, 1, 0, 1, 1);
        step(1, 1, 6, 0, 2'b01, 7, 1, 0, 1, 0);
        step(1, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        step(1, 1, 6, 0, 2'b01, 7, 1, 0, 0, 0);
        step(1, 1, 6, 0, 2'b01, 7, 1, 0, 0, 0);
        idle(2);

        // 5: x0 producers and non-writing stores never forward or stall
        step(1, 1, 1, 1, 2'b11, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 2'b11, 4, 1, 0, 0, 0);
        step(1, 1, 2, 3, 2'b11, 3, 0, 0, 0, 0);
        step(1, 1, 3, 3, 2'b11, 5, 1, 0, 0, 0);
        idle(2);

        // 6: reset mid-stall, then saturate the stall counter
        step(1, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        step(1, 1, 6, 6, 2'b11, 7, 1, 0, 0, 0);
        step(0, 1, 6, 6, 2'b11, 7, 1, 0, 1, 1);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
            step(1, 1, 6, 0, 2'b01, 7, 1, 0, 0, 0);
            step(1, 1, 6, 0, 2'b01, 7, 1, 0, 0, 0);
        end
        idle(1);
        check("t6_stall_saturated", int'(perf_stall), CMAX);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // random traffic; redirect is held through any freeze like the datapath does
        pb = 0;
        pr = 0;
        for (int i = 0; i < 800; i++) begin
            bit rv, iv, rw, mr, rd_, bz;
            rv  = ($urandom_range(0, 99) != 0);
            iv  = ($urandom_range(0, 4) != 0);
            rw  = ($urandom_range(0, 3) != 0);
            mr  = rw && ($urandom_range(0, 2) == 0);
            bz  = ($urandom_range(0, 6) == 0);
            rd_ = (pb && pr) ? 1'b1 : ($urandom_range(0, 8) == 0);
            step(rv, iv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rw, mr, rd_, bz);
            pb = bz && rv;
            pr = rd_ && rv;
        end
        idle(1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
